// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the program loader: opcode numbering (matches the core's
// decoder), error codes and loader FSM states.
package instr_encoder_loader_pkg;

   localparam int unsigned OP_W      = 4;
   localparam int unsigned ONEHOT_W  = 16;

   typedef enum logic [OP_W-1:0] {
      OP_NOOP = 4'd0,  OP_LD  = 4'd1,  OP_ST  = 4'd2,  OP_ADD = 4'd3,
      OP_SUB  = 4'd4,  OP_INC = 4'd5,  OP_MOV = 4'd6,  OP_IN  = 4'd7,
      OP_OUT  = 4'd8,  OP_CM  = 4'd9,  OP_JMP = 4'd10, OP_JP  = 4'd11,
      OP_AND  = 4'd12, OP_OR  = 4'd13, OP_XOR = 4'd14, OP_END = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_ONEHOT = 2'b01,
      ERR_OVF    = 2'b10
   } err_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_ERROR
   } state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Instruction handshake from the host and write port towards program RAM.
interface instr_encoder_loader_if #(
   parameter int ADDR_W = 4,
   parameter int OPR_W  = 4
);
   logic                in_valid;
   logic                in_ready;
   logic [15:0]         op_onehot;
   logic [OPR_W-1:0]    operand;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [3+OPR_W:0]    mem_wdata;

   modport master (
      output in_valid, op_onehot, operand,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, op_onehot, operand,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encoder_loader_onehot16_to_bin.sv
// Combinational one-hot to binary opcode encoder with an exactly-one-bit-set flag.
module onehot16_to_bin
   import instr_encoder_loader_pkg::*;
(
   input  logic [ONEHOT_W-1:0] onehot,
   output logic [OP_W-1:0]     bin,
   output logic                onehot_ok
);

   always_comb begin
      bin = '0;
      for (int unsigned i = 0; i < ONEHOT_W; i++) begin
         if (onehot[i]) bin = bin | OP_W'(i);
      end
      // x & (x-1) clears the lowest set bit; zero result means at most one bit was set
      onehot_ok = (onehot != '0) && ((onehot & (onehot - 1'b1)) == '0);
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes one-hot opcode strobes and writes {opcode,operand} bytes
// sequentially into program RAM starting at a base address.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int OPR_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   instr_encoder_loader_if.slave bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [ADDR_W:0]      words
);

   state_e            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W-1:0] last_slot;
   logic [OP_W-1:0]   bin;
   logic              onehot_ok;
   logic [OPR_W-1:0]  opr;
   logic              accept;

   onehot16_to_bin u_enc (
      .onehot    (bus.op_onehot),
      .bin       (bin),
      .onehot_ok (onehot_ok)
   );

   assign opr       = bus.operand;
   assign accept    = bus.in_valid & bus.in_ready;
   assign last_slot = base_r - 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         addr          <= '0;
         base_r        <= '0;
         words         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         err_code      <= ERR_NONE;
         bus.in_ready  <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state        <= S_LOAD;
                  addr         <= base_addr;
                  base_r       <= base_addr;
                  words        <= '0;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  err_code     <= ERR_NONE;
                  busy         <= 1'b1;
                  bus.in_ready <= 1'b1;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  if (!onehot_ok) begin
                     state        <= S_ERROR;
                     err          <= 1'b1;
                     err_code     <= ERR_ONEHOT;
                     busy         <= 1'b0;
                     bus.in_ready <= 1'b0;
                  end else begin
                     bus.mem_we    <= 1'b1;
                     bus.mem_addr  <= addr;
                     bus.mem_wdata <= {bin, opr};
                     addr          <= addr + 1'b1;
                     words         <= words + 1'b1;
                     // END wins over a full memory: END in the last slot is legal
                     if (bin == OP_END) begin
                        state        <= S_DONE;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        bus.in_ready <= 1'b0;
                     end else if (addr == last_slot) begin
                        state        <= S_ERROR;
                        err          <= 1'b1;
                        err_code     <= ERR_OVF;
                        busy         <= 1'b0;
                        bus.in_ready <= 1'b0;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader against a session-level model.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  base_addr = '0;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [4:0]  words;

   int checks = 0;
   int failures = 0;

   logic [15:0] q_op[$];
   logic [3:0]  q_opr[$];

   instr_encoder_loader_if #(.ADDR_W(4), .OPR_W(4)) bus ();

   instr_encoder_loader #(.ADDR_W(4), .OPR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .words     (words)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int onehot_index(input logic [15:0] v);
      int idx = 0;
      for (int i = 0; i < 16; i++) if (v[i]) idx = i;
      return idx;
   endfunction

   // Model: each accepted legal op lands at (base + n) mod 16; 16 non-END writes overflow
   task automatic run_session(input logic [3:0] b, input bit valid_on_start,
                              input bit rand_gaps, input bit rand_starts);
      int  k = 0;
      int  writes = 0;
      bit  fin = 0;
      bit  edone = 0;
      int  ecode = 0;
      bit  v;
      int  idx;
      base_addr     = b;
      start         = 1'b1;
      bus.in_valid  = valid_on_start;
      bus.op_onehot = q_op[0];
      bus.operand   = q_opr[0];
      tick();
      start = 1'b0;
      check_eq("start_we", 32'(bus.mem_we), 0);
      check_eq("start_ready", 32'(bus.in_ready), 1);
      check_eq("start_busy", 32'(busy), 1);
      check_eq("start_words", 32'(words), 0);
      check_eq("start_flags", {30'd0, done, err}, 0);
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         v             = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         start         = rand_starts ? ($urandom_range(0, 5) == 0) : 1'b0;
         base_addr     = 4'($urandom_range(0, 15));
         bus.in_valid  = v;
         bus.op_onehot = (k < q_op.size()) ? q_op[k] : 16'h8000;
         bus.operand   = (k < q_opr.size()) ? q_opr[k] : 4'h0;
         tick();
         start = 1'b0;
         if (v) begin
            if ($countones(bus.op_onehot) != 1) begin
               fin   = 1;
               ecode = 1;
               check_eq("bad_we", 32'(bus.mem_we), 0);
            end else begin
               idx = onehot_index(bus.op_onehot);
               check_eq("we", 32'(bus.mem_we), 1);
               check_eq("addr", 32'(bus.mem_addr), (int'(b) + writes) % 16);
               check_eq("wdata", 32'(bus.mem_wdata), idx * 16 + int'(bus.operand));
               writes++;
               if (idx == 15) begin
                  fin   = 1;
                  edone = 1;
               end else if (writes == 16) begin
                  fin   = 1;
                  ecode = 2;
               end
            end
            k++;
         end else begin
            check_eq("idle_we", 32'(bus.mem_we), 0);
         end
         check_eq("words", 32'(words), writes);
         check_eq("busy", 32'(busy), fin ? 0 : 1);
         check_eq("ready", 32'(bus.in_ready), fin ? 0 : 1);
      end
      if (!fin) check_eq("timeout", 0, 1);
      bus.in_valid = 1'b0;
      tick();
      check_eq("end_we", 32'(bus.mem_we), 0);
      check_eq("end_done", 32'(done), edone);
      check_eq("end_err", 32'(err), ecode != 0);
      check_eq("end_code", 32'(err_code), ecode);
      check_eq("end_words", 32'(words), writes);
   endtask

   task automatic push(input logic [15:0] op, input logic [3:0] opr);
      q_op.push_back(op);
      q_opr.push_back(opr);
   endtask

   task automatic clear_q();
      q_op.delete();
      q_opr.delete();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.op_onehot = '0;
      bus.operand   = '0;
      #12;
      check_eq("rst_we", 32'(bus.mem_we), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_words", 32'(words), 0);
      check_eq("rst_flags", {28'd0, done, err, err_code}, 0);
      @(negedge clk);
      rst = 1'b0;

      // async reset while a write is on the bus
      base_addr     = 4'h3;
      start         = 1'b1;
      tick();
      start         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.op_onehot = 16'h0004;
      bus.operand   = 4'h9;
      tick();
      bus.in_valid = 1'b0;
      check_eq("pre_rst_we", 32'(bus.mem_we), 1);
      check_eq("pre_rst_wdata", 32'(bus.mem_wdata), 32'h29);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_we", 32'(bus.mem_we), 0);
      check_eq("arst_busy", 32'(busy), 0);
      check_eq("arst_words", 32'(words), 0);
      check_eq("arst_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      check_eq("idle_no_accept", 32'(bus.mem_we), 0);
      bus.in_valid = 1'b0;

      clear_q(); push(16'h0002, 4'h3); push(16'h0008, 4'h5); push(16'h8000, 4'h0);
      run_session(4'h0, 0, 0, 0);

      clear_q(); push(16'h0006, 4'h1);
      run_session(4'h5, 0, 0, 0);

      clear_q();
      for (int i = 0; i < 16; i++) push(16'h0001 << $urandom_range(0, 14), 4'($urandom));
      run_session(4'hE, 0, 0, 0);

      clear_q();
      for (int i = 0; i < 15; i++) push(16'h0001 << $urandom_range(0, 14), 4'($urandom));
      push(16'h8000, 4'h7);
      run_session(4'hE, 0, 0, 0);

      clear_q(); push(16'h0020, 4'hA); push(16'h8000, 4'h1);
      run_session(4'h8, 1, 0, 0);

      clear_q();
      for (int i = 0; i < 6; i++) push(16'h0001 << $urandom_range(0, 14), 4'($urandom));
      push(16'h8000, 4'h0);
      run_session(4'h2, 0, 1, 1);

      for (int s = 0; s < 30; s++) begin
         int n = $urandom_range(1, 20);
         clear_q();
         for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 19);
            if (r == 0)      push(16'h0000, 4'($urandom));
            else if (r == 1) push(16'h0003 << $urandom_range(0, 14), 4'($urandom));
            else if (r == 2) push(16'h8000, 4'($urandom));
            else             push(16'h0001 << $urandom_range(0, 14), 4'($urandom));
         end
         push(16'h8000, 4'($urandom));
         run_session(4'($urandom_range(0, 15)), s[0], 1, s[1]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
      $fatal(1, "watchdog expired");
   end

endmodule
